// File: rtl/tcm_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tcm_port_arbiter                                              |
// | Purpose  : Shares one single-port TCM (1-cycle read latency, byte-masked |
// |            write) between two requesters: m0 (core LSU) and m1           |
// |            (debug/DMA). One outstanding access, round-robin or fixed     |
// |            priority, back-to-back throughput of one access per cycle.    |
// | Ports    :                                                               |
// |   clk, rst_n          clock, asynchronous active-low reset               |
// |   mN_req_*            request channel (valid/ready, addr, we, wem, wdata)|
// |   mN_rsp_*            response channel (valid/ready, rdata, err)         |
// |   ram_addr/we/wem/din RAM command, driven in the grant cycle             |
// |   ram_dout            RAM read data, valid the cycle after the address   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tcm_port_arbiter #(
  parameter int DP        = 512,
  parameter int DW        = 32,
  parameter int MW        = 4,
  parameter int AW        = 32,
  parameter int FIXED_PRI = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // requester 0
  input  logic                  m0_req_valid,
  output logic                  m0_req_ready,
  input  logic [AW-1:0]         m0_req_addr,
  input  logic                  m0_req_we,
  input  logic [MW-1:0]         m0_req_wem,
  input  logic [DW-1:0]         m0_req_wdata,
  output logic                  m0_rsp_valid,
  input  logic                  m0_rsp_ready,
  output logic [DW-1:0]         m0_rsp_rdata,
  output logic                  m0_rsp_err,
  // requester 1
  input  logic                  m1_req_valid,
  output logic                  m1_req_ready,
  input  logic [AW-1:0]         m1_req_addr,
  input  logic                  m1_req_we,
  input  logic [MW-1:0]         m1_req_wem,
  input  logic [DW-1:0]         m1_req_wdata,
  output logic                  m1_rsp_valid,
  input  logic                  m1_rsp_ready,
  output logic [DW-1:0]         m1_rsp_rdata,
  output logic                  m1_rsp_err,
  // RAM side
  output logic [$clog2(DP)-1:0] ram_addr,
  output logic                  ram_we,
  output logic [MW-1:0]         ram_wem,
  output logic [DW-1:0]         ram_din,
  input  logic [DW-1:0]         ram_dout
);

  localparam int            RAM_AW   = $clog2(DP);
  // Depth expressed at word-index width plus one bit so the compare below
  // never truncates DP.
  localparam logic [AW-2:0] DP_WORDS = (AW-1)'(DP);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RESP = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;       // port whose response is pending
  logic              wr_q, wr_d;             // pending access was a write
  logic              err_q, err_d;           // pending access was out of range
  logic              rr_ptr_q, rr_ptr_d;     // port that wins the next conflict
  logic [RAM_AW-1:0] hold_addr_q, hold_addr_d;

  // Byte-offset bits play no role in a word-wide TCM.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{m0_req_addr[1:0], m1_req_addr[1:0]};

  function automatic logic out_of_range(input logic [AW-3:0] word);
    return {1'b0, word} >= DP_WORDS;
  endfunction

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
  logic          owner_rsp_ready;
  logic          win_open;
  logic          gnt_any;
  logic          gnt_port;
  logic [AW-3:0] sel_word;
  logic          sel_we;
  logic [MW-1:0] sel_wem;
  logic [DW-1:0] sel_wdata;
  logic          sel_err;

  always_comb begin
    owner_rsp_ready = owner_q ? m1_rsp_ready : m0_rsp_ready;

    // A new access may start when idle or when the pending response is being
    // consumed this very cycle. Gating with rst_n keeps every ready low while
    // reset is asserted, independent of requester activity.
    win_open = rst_n & ((state_q == S_IDLE) |
                        ((state_q == S_RESP) & owner_rsp_ready));

    gnt_any = win_open & (m0_req_valid | m1_req_valid);

    if (m0_req_valid & m1_req_valid) begin
      gnt_port = (FIXED_PRI != 0) ? 1'b0 : rr_ptr_q;
    end else begin
      gnt_port = ~m0_req_valid;
    end

    sel_word  = gnt_port ? m1_req_addr[AW-1:2] : m0_req_addr[AW-1:2];
    sel_we    = gnt_port ? m1_req_we           : m0_req_we;
    sel_wem   = gnt_port ? m1_req_wem          : m0_req_wem;
    sel_wdata = gnt_port ? m1_req_wdata        : m0_req_wdata;
    sel_err   = out_of_range(sel_word);
  end

  assign m0_req_ready = gnt_any & ~gnt_port;
  assign m1_req_ready = gnt_any &  gnt_port;

  // --------------------------------------------------------------------------
  // RAM command
  // --------------------------------------------------------------------------
  always_comb begin
    // Outside a grant the RAM keeps reading the held word, so a stalled read
    // response keeps seeing the same data on ram_dout.
    ram_addr = (state_q == S_RESP) ? hold_addr_q : '0;
    ram_we   = 1'b0;
    ram_wem  = '0;
    ram_din  = '0;
    if (gnt_any) begin
      ram_addr = sel_word[RAM_AW-1:0];
      ram_we   = sel_we & ~sel_err;
      ram_wem  = sel_wem;
      ram_din  = sel_wdata;
    end
  end

  // --------------------------------------------------------------------------
  // Next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    wr_d        = wr_q;
    err_d       = err_q;
    rr_ptr_d    = rr_ptr_q;
    hold_addr_d = hold_addr_q;

    if (gnt_any) begin
      // Covers both the idle start and the back-to-back hand-over where the
      // previous response completes in the same cycle.
      state_d     = S_RESP;
      owner_d     = gnt_port;
      wr_d        = sel_we;
      err_d       = sel_err;
      hold_addr_d = sel_word[RAM_AW-1:0];
      if (FIXED_PRI == 0) begin
        rr_ptr_d = ~gnt_port;
      end
    end else if ((state_q == S_RESP) & owner_rsp_ready) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      owner_q     <= 1'b0;
      wr_q        <= 1'b0;
      err_q       <= 1'b0;
      rr_ptr_q    <= 1'b0;
      hold_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      wr_q        <= wr_d;
      err_q       <= err_d;
      rr_ptr_q    <= rr_ptr_d;
      hold_addr_q <= hold_addr_d;
    end
  end

  // --------------------------------------------------------------------------
  // Response channel
  // --------------------------------------------------------------------------
  logic          rsp_active;
  logic [DW-1:0] rsp_data;

  always_comb begin
    rsp_active = (state_q == S_RESP);
    // Writes and rejected accesses never expose RAM contents.
    rsp_data   = (~wr_q & ~err_q) ? ram_dout : '0;
  end

  assign m0_rsp_valid = rsp_active & ~owner_q;
  assign m1_rsp_valid = rsp_active &  owner_q;
  assign m0_rsp_rdata = m0_rsp_valid ? rsp_data : '0;
  assign m1_rsp_rdata = m1_rsp_valid ? rsp_data : '0;
  assign m0_rsp_err   = m0_rsp_valid & err_q;
  assign m1_rsp_err   = m1_rsp_valid & err_q;

endmodule
`default_nettype wire

// File: tb/tb_tcm_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_tcm_port_arbiter                                           |
// | Purpose  : Self-checking bench for tcm_port_arbiter: directed scenarios  |
// |            followed by random traffic against a transaction-level model |
// |            holding the memory image, busy flag, owner and RR pointer.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_tcm_port_arbiter;

  localparam int DP = 512;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // stimulus, index = port
  logic [1:0]  v, we, rr;
  logic [31:0] addr [2];
  logic [3:0]  wem  [2];
  logic [31:0] wd   [2];

  // DUT (round-robin)
  logic        m0_req_ready, m1_req_ready, m0_rsp_valid, m1_rsp_valid;
  logic        m0_rsp_err, m1_rsp_err;
  logic [31:0] m0_rsp_rdata, m1_rsp_rdata;
  logic [8:0]  ram_addr;
  logic        ram_we;
  logic [3:0]  ram_wem;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;

  tcm_port_arbiter #(.DP(DP), .DW(32), .MW(4), .AW(32), .FIXED_PRI(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req_valid(v[0]), .m0_req_ready(m0_req_ready), .m0_req_addr(addr[0]),
    .m0_req_we(we[0]), .m0_req_wem(wem[0]), .m0_req_wdata(wd[0]),
    .m0_rsp_valid(m0_rsp_valid), .m0_rsp_ready(rr[0]), .m0_rsp_rdata(m0_rsp_rdata),
    .m0_rsp_err(m0_rsp_err),
    .m1_req_valid(v[1]), .m1_req_ready(m1_req_ready), .m1_req_addr(addr[1]),
    .m1_req_we(we[1]), .m1_req_wem(wem[1]), .m1_req_wdata(wd[1]),
    .m1_rsp_valid(m1_rsp_valid), .m1_rsp_ready(rr[1]), .m1_rsp_rdata(m1_rsp_rdata),
    .m1_rsp_err(m1_rsp_err),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wem(ram_wem), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  // DUT (fixed priority), only its grant pattern is examined
  logic        fp_m0_req_ready, fp_m1_req_ready, fp_m0_rsp_valid, fp_m1_rsp_valid;
  logic        fp_m0_rsp_err, fp_m1_rsp_err;
  logic [31:0] fp_m0_rsp_rdata, fp_m1_rsp_rdata;
  logic [8:0]  fp_ram_addr;
  logic        fp_ram_we;
  logic [3:0]  fp_ram_wem;
  logic [31:0] fp_ram_din;
  logic [31:0] fp_ram_dout = 32'h0;

  tcm_port_arbiter #(.DP(DP), .DW(32), .MW(4), .AW(32), .FIXED_PRI(1)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .m0_req_valid(v[0]), .m0_req_ready(fp_m0_req_ready), .m0_req_addr(addr[0]),
    .m0_req_we(we[0]), .m0_req_wem(wem[0]), .m0_req_wdata(wd[0]),
    .m0_rsp_valid(fp_m0_rsp_valid), .m0_rsp_ready(rr[0]), .m0_rsp_rdata(fp_m0_rsp_rdata),
    .m0_rsp_err(fp_m0_rsp_err),
    .m1_req_valid(v[1]), .m1_req_ready(fp_m1_req_ready), .m1_req_addr(addr[1]),
    .m1_req_we(we[1]), .m1_req_wem(wem[1]), .m1_req_wdata(wd[1]),
    .m1_rsp_valid(fp_m1_rsp_valid), .m1_rsp_ready(rr[1]), .m1_rsp_rdata(fp_m1_rsp_rdata),
    .m1_rsp_err(fp_m1_rsp_err),
    .ram_addr(fp_ram_addr), .ram_we(fp_ram_we), .ram_wem(fp_ram_wem), .ram_din(fp_ram_din),
    .ram_dout(fp_ram_dout)
  );

  // Single-port RAM attached to the round-robin DUT
  logic [31:0] ram_mem [DP];
  always @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_wem[b]) ram_mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
      end
    end
    ram_dout <= ram_mem[ram_addr];
  end

  // per-port views of DUT outputs
  logic [1:0]  o_ready, o_valid, o_err;
  logic [31:0] o_rdata [2];
  assign o_ready    = {m1_req_ready, m0_req_ready};
  assign o_valid    = {m1_rsp_valid, m0_rsp_valid};
  assign o_err      = {m1_rsp_err, m0_rsp_err};
  assign o_rdata[0] = m0_rsp_rdata;
  assign o_rdata[1] = m1_rsp_rdata;

  // reference model
  logic [31:0] ref_mem [DP];
  bit          m_busy;
  int          m_owner;
  bit          m_rr;
  bit          m_err;
  logic [31:0] m_rdata;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit check_fp = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s@%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic set_req(input int p, input bit valid, input bit write,
                         input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
    v[p]    = valid;
    we[p]   = write;
    addr[p] = a;
    wem[p]  = m;
    wd[p]   = d;
  endtask

  task automatic model_reset();
    m_busy  = 1'b0;
    m_owner = 0;
    m_rr    = 1'b0;
    m_err   = 1'b0;
    m_rdata = '0;
  endtask

  // Called right after a falling edge with inputs already applied: checks the
  // cycle's outputs, advances the model across the rising edge, returns on the
  // next falling edge.
  task automatic step();
    bit          win;
    int          g;
    logic [29:0] idx;
    bit          e;
    #2;
    for (int p = 0; p < 2; p++) begin
      bit ev;
      ev = m_busy && (m_owner == p);
      chk($sformatf("rsp_valid%0d", p), o_valid[p], ev);
      chk($sformatf("rsp_rdata%0d", p), o_rdata[p], ev ? m_rdata : 32'h0);
      chk($sformatf("rsp_err%0d", p), o_err[p], ev ? m_err : 1'b0);
    end
    win = !m_busy || rr[m_owner];
    g = -1;
    if (win) begin
      if (v[0] && v[1]) g = m_rr ? 1 : 0;
      else if (v[0])    g = 0;
      else if (v[1])    g = 1;
    end
    chk("req_ready0", o_ready[0], g == 0);
    chk("req_ready1", o_ready[1], g == 1);
    if (check_fp) begin
      chk("fp_ready0", fp_m0_req_ready, 1'b1);
      chk("fp_ready1", fp_m1_req_ready, 1'b0);
    end
    if (m_busy && !win) chk("stall_ram_we", ram_we, 1'b0);
    if (g >= 0) begin
      idx = addr[g][31:2];
      e   = idx >= 30'(DP);
      chk("grant_ram_we", ram_we, we[g] && !e);
      if (!e) chk("grant_ram_addr", ram_addr, idx[8:0]);
      if (we[g] && !e) chk("grant_ram_din", ram_din, wd[g]);
      m_busy  = 1'b1;
      m_owner = g;
      m_rr    = (g == 0);
      m_err   = e;
      if (we[g] && !e) begin
        for (int b = 0; b < 4; b++)
          if (wem[g][b]) ref_mem[idx[8:0]][8*b +: 8] = wd[g][8*b +: 8];
      end
      m_rdata = (we[g] || e) ? 32'h0 : ref_mem[idx[8:0]];
    end else if (m_busy && rr[m_owner]) begin
      m_busy = 1'b0;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic reset_check();
    chk("rst_req_ready0", m0_req_ready, 1'b0);
    chk("rst_req_ready1", m1_req_ready, 1'b0);
    chk("rst_rsp_valid0", m0_rsp_valid, 1'b0);
    chk("rst_rsp_valid1", m1_rsp_valid, 1'b0);
    chk("rst_rsp_err", {m1_rsp_err, m0_rsp_err}, 2'b00);
    chk("rst_rdata0", m0_rsp_rdata, 32'h0);
    chk("rst_rdata1", m1_rsp_rdata, 32'h0);
    chk("rst_ram_we", ram_we, 1'b0);
    chk("rst_ram_wem", ram_wem, 4'h0);
    chk("rst_ram_addr", ram_addr, 9'h0);
    chk("rst_ram_din", ram_din, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < DP; i++) begin
      ram_mem[i] = $urandom;
      ref_mem[i] = ram_mem[i];
    end
    model_reset();
    set_req(0, 0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0, 0);
    rr = 2'b00;

    // power-on reset, with requests pending
    @(negedge clk);
    set_req(0, 1, 0, 32'h10, 4'h0, 0);
    set_req(1, 1, 0, 32'h14, 4'h0, 0);
    #2 reset_check();
    @(negedge clk);
    rst_n = 1'b1;
    set_req(1, 0, 0, 0, 0, 0);

    // reset while an m0 read response is stalled
    step();                                   // m0 read 0x10 granted
    set_req(0, 0, 0, 0, 0, 0);
    step();                                   // response stalled
    rst_n = 1'b0;
    set_req(0, 1, 0, 32'h20, 4'h0, 0);
    set_req(1, 1, 0, 32'h24, 4'h0, 0);
    #2 reset_check();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    rr = 2'b11;
    step();                                   // both valid: m0 must win
    set_req(0, 0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0, 0);
    step();
    step();

    // masked write then read-back of word 2
    set_req(0, 1, 1, 32'h8, 4'b0011, 32'hA5A5_A5A5);
    step();
    set_req(0, 1, 0, 32'h8, 4'h0, 0);
    step();
    set_req(0, 0, 0, 0, 0, 0);
    #1 chk("t2_low_half", m0_rsp_rdata[15:0], 16'hA5A5);
    step();
    step();

    // both requesters hammering reads
    check_fp = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_req(0, 1, 0, {21'h0, 9'($urandom_range(0, DP-1)), 2'b00}, 0, 0);
      set_req(1, 1, 0, {21'h0, 9'($urandom_range(0, DP-1)), 2'b00}, 0, 0);
      step();
    end
    check_fp = 1'b0;
    set_req(0, 0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0, 0);
    step();

    // stalled m1 read response with m0 waiting
    set_req(1, 1, 1, 32'h4, 4'hF, 32'h1234_5678);
    step();
    set_req(1, 1, 0, 32'h4, 4'h0, 0);
    step();
    set_req(1, 0, 0, 0, 0, 0);
    set_req(0, 1, 0, 32'h40, 4'h0, 0);
    rr = 2'b01;
    for (int i = 0; i < 5; i++) step();
    #1 chk("t4_held_rdata", m1_rsp_rdata, 32'h1234_5678);
    rr = 2'b11;
    step();                                   // m0 granted as m1 completes
    set_req(0, 0, 0, 0, 0, 0);
    step();

    // out of range at DP*4, then word 0 must be untouched
    set_req(0, 1, 1, 32'h800, 4'hF, 32'hDEAD_BEEF);
    step();
    set_req(0, 1, 0, 32'h800, 4'h0, 0);
    step();
    set_req(0, 1, 0, 32'h0, 4'h0, 0);
    step();
    // last word and top address bit
    set_req(0, 1, 0, 32'h7FC, 4'h0, 0);
    step();
    set_req(0, 1, 0, 32'h8000_0008, 4'h0, 0);
    step();
    set_req(0, 0, 0, 0, 0, 0);
    step();

    // random traffic
    for (int i = 0; i < 600; i++) begin
      for (int p = 0; p < 2; p++) begin
        logic [31:0] a;
        if ($urandom_range(0, 7) == 0) a = $urandom;
        else a = {21'h0, 9'($urandom_range(0, DP-1)), 2'($urandom)};
        set_req(p, $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, a,
                4'($urandom), $urandom);
        rr[p] = $urandom_range(0, 3) != 0;
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
